// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU opcodes, widths and arbiter FSM state encodings.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;
    localparam int ALU_DW  = 8;
    localparam int ALU_OPW = 3;

    localparam logic [ALU_OPW-1:0] ALU_OP_FWD = 3'b000;
    localparam logic [ALU_OPW-1:0] ALU_OP_ADD = 3'b001;
    localparam logic [ALU_OPW-1:0] ALU_OP_AND = 3'b010;
    localparam logic [ALU_OPW-1:0] ALU_OP_OR  = 3'b011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter_if
// Brief   : Requester handshakes plus the ALU drive/return bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import alu_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [ALU_OPW*NUM_REQ-1:0] req_op;
    logic [ALU_DW*NUM_REQ-1:0]  req_a;
    logic [ALU_DW*NUM_REQ-1:0]  req_b;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [NUM_REQ-1:0]         resp_ready;
    logic [ALU_DW-1:0]          resp_result;
    logic                       resp_zero;
    logic [ALU_DW-1:0]          ALU_DATA1;
    logic [ALU_DW-1:0]          ALU_DATA2;
    logic [ALU_OPW-1:0]         ALU_SELECT;
    logic [ALU_DW-1:0]          ALU_RESULT;
    logic                       ALU_ZERO;

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, ALU_RESULT, ALU_ZERO,
        output req_ready, resp_valid, resp_result, resp_zero,
               ALU_DATA1, ALU_DATA2, ALU_SELECT
    );

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, ALU_RESULT, ALU_ZERO,
        input  req_ready, resp_valid, resp_result, resp_zero,
               ALU_DATA1, ALU_DATA2, ALU_SELECT
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin pick starting the search at ptr_i.
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    always_comb begin
        int pos;
        pos     = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && |(req_i & (NUM_REQ'(1) << pos))) begin
                any_o   = 1'b1;
                grant_o = NUM_REQ'(1) << pos;
                idx_o   = IW'(pos);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin sharing of one external ALU between NUM_REQ clients.
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ALU_WAIT = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    alu_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT + 1) : 1;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ALU_DW-1:0]  data1_q, data1_d;
    logic [ALU_DW-1:0]  data2_q, data2_d;
    logic [ALU_OPW-1:0] sel_q, sel_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [ALU_DW-1:0]  result_q, result_d;
    logic               zero_q, zero_d;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    assign bus.req_ready   = (state_q == ST_IDLE) ? grant : '0;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign bus.ALU_DATA1   = data1_q;
    assign bus.ALU_DATA2   = data2_q;
    assign bus.ALU_SELECT  = sel_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        sel_d        = sel_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    sel_d    = ALU_OPW'(bus.req_op >> (ALU_OPW * int'(grant_idx)));
                    data1_d  = ALU_DW'(bus.req_a >> (ALU_DW * int'(grant_idx)));
                    data2_d  = ALU_DW'(bus.req_b >> (ALU_DW * int'(grant_idx)));
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d    = CW'(ALU_WAIT);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU result settles ALU_WAIT edges after the operands were driven
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d     = bus.ALU_RESULT;
                    zero_d       = bus.ALU_ZERO;
                    resp_valid_d = NUM_REQ'(1) << owner_q;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (|(bus.resp_ready & resp_valid_q)) begin
                    resp_valid_d = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            sel_q        <= ALU_OP_FWD;
            resp_valid_q <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            sel_q        <= sel_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end
endmodule
`default_nettype wire
